// File: rtl/robot_pkg.sv
// ---------------------------------------------------------------------------
// robot_pkg
// Shared definitions for the wall-following robot controller:
//   - state_t : state encoding driven onto q (SEEK=0 .. HALT=4)
//   - DEF_*   : default parameter values used by robot_follower_param and
//               robot_timer
// ---------------------------------------------------------------------------
package robot_pkg;

  typedef enum logic [2:0] {
    ST_SEEK   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_ROTATE = 3'd2,
    ST_LOST   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam int DEF_ROT_CYCLES  = 4;
  localparam int DEF_LOST_LIMIT  = 8;
  localparam int DEF_WALL_RIGHT  = 0;
  localparam int DEF_STALL_LIMIT = 3;

endpackage

// File: rtl/robot_timer.sv
// ---------------------------------------------------------------------------
// robot_timer
// Loadable saturating down-counter timing one rotation step.
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset (count -> 0)
//   i_clr    in  synchronous clear (count -> 0), highest synchronous priority
//   i_load   in  load LOAD_VAL
//   i_dec    in  decrement by one, saturating at 0
//   o_done   out this cycle is the last cycle of the step (count <= 1)
// ---------------------------------------------------------------------------
module robot_timer
  import robot_pkg::*;
#(
  parameter int LOAD_VAL = DEF_ROT_CYCLES,
  parameter int WIDTH    = $clog2(LOAD_VAL + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_dec,
  output logic o_done
);

  logic [WIDTH-1:0] r_count;

  // Count register: clear > load > saturating decrement > hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_clr) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_count <= WIDTH'(LOAD_VAL);
    end else if (i_dec && (r_count != {WIDTH{1'b0}})) begin
      r_count <= r_count - WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // Done while the count sits at 1 (the edge that takes it to 0) so a step
  // loaded with N lasts exactly N cycles; 0 also counts as done.
  assign o_done = (r_count <= WIDTH'(1));

endmodule

// File: rtl/robot_follower_param.sv
// ---------------------------------------------------------------------------
// robot_follower_param
// Wall-following robot controller (SEEK / FOLLOW / ROTATE / LOST / HALT).
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset, priority over preset
//   preset   in  synchronous force into FOLLOW, clears all counters
//   h        in  head (front) obstacle sensor
//   s        in  side wall sensor on the followed side
//   a        out advance command
//   r        out rotate command
//   rdir     out rotation direction (1 = toward followed wall, only in LOST)
//   q / nq   out current state encoding and its bitwise inverse
//   stall    out stall indication (HALT)
// Configuration macro: ROBOT_STALL_DETECT_EN enables the stall counter and
// the HALT state; when undefined HALT is unreachable and stall is 0.
// WALL_RIGHT only documents which side the s sensor is mounted on.
// ---------------------------------------------------------------------------
module robot_follower_param
  import robot_pkg::*;
#(
  parameter int ROT_CYCLES  = DEF_ROT_CYCLES,
  parameter int LOST_LIMIT  = DEF_LOST_LIMIT,
  parameter int WALL_RIGHT  = DEF_WALL_RIGHT,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       preset,
  input  logic       h,
  input  logic       s,
  output logic       a,
  output logic       r,
  output logic       rdir,
  output logic [2:0] q,
  output logic [2:0] nq,
  output logic       stall
);

  localparam int LOST_W = $clog2(LOST_LIMIT + 1);

  if ((ROT_CYCLES < 1) || (LOST_LIMIT < 1) || (STALL_LIMIT < 1) ||
      (WALL_RIGHT < 0) || (WALL_RIGHT > 1)) begin : g_bad_cfg
    $error("robot_follower_param: invalid parameter set");
  end

  state_t            r_state;
  state_t            w_next;
  logic [LOST_W-1:0] r_lost_cnt;
  logic [LOST_W-1:0] w_lost_next;
  logic              w_rot_entry;
  logic              w_rot_load;
  logic              w_rot_done;
  logic              w_seek_follow;
  logic              w_a;

`ifdef ROBOT_STALL_DETECT_EN
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  logic [STALL_W-1:0] r_stall_cnt;
  logic [STALL_W-1:0] w_stall_next;
`endif

  robot_timer #(
    .LOAD_VAL (ROT_CYCLES)
  ) u_rot_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (preset),
    .i_load  (w_rot_load),
    .i_dec   (r_state == ST_ROTATE),
    .o_done  (w_rot_done)
  );

  assign w_seek_follow = (r_state == ST_SEEK) || (r_state == ST_FOLLOW);
  assign w_a           = w_seek_follow && !h;

  // Next-state, lost counter and stall counter update.
  always_comb begin
    w_next      = r_state;
    w_rot_entry = 1'b0;
    w_lost_next = {LOST_W{1'b0}};
`ifdef ROBOT_STALL_DETECT_EN
    w_stall_next = r_stall_cnt;
`endif
    case (r_state)
      ST_SEEK: begin
        if (h) begin
          w_rot_entry = 1'b1;
        end else if (s) begin
          w_next = ST_FOLLOW;
        end else begin
          w_next = ST_SEEK;
        end
      end
      ST_FOLLOW: begin
        if (h) begin
          w_rot_entry = 1'b1;
        end else if (s) begin
          w_lost_next = {LOST_W{1'b0}};
        end else begin
          // Going LOST on the edge where the count reaches LOST_LIMIT.
          if (r_lost_cnt >= LOST_W'(LOST_LIMIT - 1)) begin
            w_next = ST_LOST;
          end else begin
            w_next = ST_FOLLOW;
          end
          if (r_lost_cnt == LOST_W'(LOST_LIMIT)) begin
            w_lost_next = r_lost_cnt;
          end else begin
            w_lost_next = r_lost_cnt + LOST_W'(1);
          end
        end
      end
      ST_ROTATE: begin
        if (!w_rot_done) begin
          w_next = ST_ROTATE;
        end else if (h) begin
          w_rot_entry = 1'b1;
        end else if (s) begin
          w_next = ST_FOLLOW;
        end else begin
          w_next = ST_SEEK;
        end
      end
      ST_LOST: begin
        if (h) begin
          w_rot_entry = 1'b1;
        end else if (s) begin
          w_next = ST_FOLLOW;
        end else begin
          w_next = ST_LOST;
        end
      end
      ST_HALT: begin
        w_next = ST_HALT;
      end
      default: begin
        w_next = ST_SEEK;
      end
    endcase

    // Every ROTATE entry (including a restart) goes through here; with stall
    // detection the STALL_LIMIT-th entry since the last advance halts.
    if (w_rot_entry) begin
      w_next = ST_ROTATE;
`ifdef ROBOT_STALL_DETECT_EN
      if (r_stall_cnt >= STALL_W'(STALL_LIMIT - 1)) begin
        w_next = ST_HALT;
      end else begin
        w_next = ST_ROTATE;
      end
      if (r_stall_cnt == STALL_W'(STALL_LIMIT)) begin
        w_stall_next = r_stall_cnt;
      end else begin
        w_stall_next = r_stall_cnt + STALL_W'(1);
      end
`endif
    end else begin
`ifdef ROBOT_STALL_DETECT_EN
      if (w_a) begin
        w_stall_next = {STALL_W{1'b0}};
      end else begin
        w_stall_next = r_stall_cnt;
      end
`endif
    end
  end

  assign w_rot_load = w_rot_entry && (w_next == ST_ROTATE);

  // State and counter registers; reset_n wins over preset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_SEEK;
      r_lost_cnt <= {LOST_W{1'b0}};
    end else if (preset) begin
      r_state    <= ST_FOLLOW;
      r_lost_cnt <= {LOST_W{1'b0}};
    end else begin
      r_state    <= w_next;
      r_lost_cnt <= w_lost_next;
    end
  end

`ifdef ROBOT_STALL_DETECT_EN
  // Stall counter: ROTATE entries since the last cycle with a=1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= {STALL_W{1'b0}};
    end else if (preset) begin
      r_stall_cnt <= {STALL_W{1'b0}};
    end else begin
      r_stall_cnt <= w_stall_next;
    end
  end
  assign stall = (r_state == ST_HALT);
`else
  assign stall = 1'b0;
`endif

  assign a    = w_a;
  assign r    = (r_state == ST_ROTATE) || (r_state == ST_LOST) || (w_seek_follow && h);
  assign rdir = (r_state == ST_LOST);
  assign q    = r_state;
  assign nq   = ~r_state;

endmodule

// File: tb/tb_robot_follower_param.sv
// ---------------------------------------------------------------------------
// tb_robot_follower_param
// Directed-vector bench for robot_follower_param with default parameters.
// ---------------------------------------------------------------------------
module tb_robot_follower_param;

  logic       clk;
  logic       reset_n;
  logic       preset;
  logic       h;
  logic       s;
  logic       a;
  logic       r;
  logic       rdir;
  logic [2:0] q;
  logic [2:0] nq;
  logic       stall;

  int n_tests;
  int n_fail;

  robot_follower_param dut (
    .clk     (clk),
    .reset_n (reset_n),
    .preset  (preset),
    .h       (h),
    .s       (s),
    .a       (a),
    .r       (r),
    .rdir    (rdir),
    .q       (q),
    .nq      (nq),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    preset  = 1'b0;
    h       = 1'b0;
    s       = 1'b0;

    // Reset state, before any clock edge.
    #2;
    check_eq("rst_q", {5'd0, q}, 8'd0);
    check_eq("rst_nq", {5'd0, nq}, 8'd7);
    check_eq("rst_a", {7'd0, a}, 8'd1);
    check_eq("rst_r", {7'd0, r}, 8'd0);
    check_eq("rst_stall", {7'd0, stall}, 8'd0);
    h = 1'b1;
    #1;
    check_eq("rst_a_h", {7'd0, a}, 8'd0);
    check_eq("rst_r_h", {7'd0, r}, 8'd1);
    check_eq("rst_rdir", {7'd0, rdir}, 8'd0);
    h = 1'b0;
    #1;
    reset_n = 1'b1;
    s = 1'b1;
    tick();
    check_eq("seek_to_follow", {5'd0, q}, 8'd1);

    // FOLLOW, obstacle for one edge -> ROTATE for exactly 4 cycles.
    h = 1'b1;
    tick();
    h = 1'b0;
    s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("rot_q", {5'd0, q}, 8'd2);
      check_eq("rot_r", {7'd0, r}, 8'd1);
      check_eq("rot_a", {7'd0, a}, 8'd0);
      tick();
    end
    check_eq("rot_to_follow", {5'd0, q}, 8'd1);

    // Lost counter is cleared by s=1: 5 lost cycles, one seen, then 8 more.
    s = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("lost_partial", {5'd0, q}, 8'd1);
    s = 1'b1;
    tick();
    s = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check_eq("follow_adv", {7'd0, a}, 8'd1);
      tick();
      if (i < 8) check_eq("lost_wait", {5'd0, q}, 8'd1);
    end
    check_eq("lost_q", {5'd0, q}, 8'd3);
    check_eq("lost_r", {7'd0, r}, 8'd1);
    check_eq("lost_rdir", {7'd0, rdir}, 8'd1);
    check_eq("lost_a", {7'd0, a}, 8'd0);
    s = 1'b1;
    tick();
    check_eq("lost_to_follow", {5'd0, q}, 8'd1);
    check_eq("follow_rdir", {7'd0, rdir}, 8'd0);

    // ROTATE with h held high.
    h = 1'b1;
    s = 1'b0;
    tick();
    check_eq("hold_entry", {5'd0, q}, 8'd2);
`ifdef ROBOT_STALL_DETECT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("stall_rot_q", {5'd0, q}, 8'd2);
      check_eq("stall_rot_a", {7'd0, a}, 8'd0);
    end
    tick();
    check_eq("halt_q", {5'd0, q}, 8'd4);
    check_eq("halt_stall", {7'd0, stall}, 8'd1);
    check_eq("halt_a", {7'd0, a}, 8'd0);
    check_eq("halt_r", {7'd0, r}, 8'd0);
    tick();
    check_eq("halt_stays", {5'd0, q}, 8'd4);
`else
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("hold_q", {5'd0, q}, 8'd2);
      check_eq("hold_a", {7'd0, a}, 8'd0);
      check_eq("hold_stall", {7'd0, stall}, 8'd0);
    end
`endif
    preset = 1'b1;
    tick();
    preset = 1'b0;
    check_eq("preset_q", {5'd0, q}, 8'd1);
    check_eq("preset_stall", {7'd0, stall}, 8'd0);

    // ROTATE ending with h=0,s=0 falls back to SEEK; SEEK holds with no walls.
    h = 1'b1;
    tick();
    h = 1'b0;
    s = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("rot_to_seek", {5'd0, q}, 8'd0);
    tick();
    check_eq("seek_hold", {5'd0, q}, 8'd0);
    check_eq("seek_a", {7'd0, a}, 8'd1);

    // Async reset between edges mid-ROTATE.
    h = 1'b1;
    tick();
    tick();
    check_eq("mid_rot", {5'd0, q}, 8'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_q", {5'd0, q}, 8'd0);
    check_eq("async_nq", {5'd0, nq}, 8'd7);
    check_eq("async_r", {7'd0, r}, 8'd1);
    // reset_n has priority over preset.
    preset = 1'b1;
    tick();
    check_eq("rst_over_preset", {5'd0, q}, 8'd0);
    reset_n = 1'b1;
    tick();
    preset = 1'b0;
    check_eq("preset_after_rst", {5'd0, q}, 8'd1);

    // Fresh rotation after reset lasts exactly 4 cycles.
    h = 1'b1;
    tick();
    h = 1'b0;
    s = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("rot_4th_cycle", {5'd0, q}, 8'd2);
    tick();
    check_eq("rot_done_follow", {5'd0, q}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
